// File: rtl/pwm_sweep_pkg.sv
// Shared types and the duty-sweep step rule for the PWM sweep master.
// All duty arithmetic is done in 9 bits so that duty+step can never wrap.
package pwm_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StWaitTick
    } state_t;

    typedef enum logic {
        ModeSaw,
        ModeTri
    } mode_t;

    typedef enum logic {
        DirUp,
        DirDown
    } dir_t;

    typedef struct packed {
        logic [7:0] duty;
        dir_t       dir;
    } duty_step_t;

    function automatic duty_step_t next_duty(
        input logic [7:0] duty,
        input dir_t       dir,
        input mode_t      mode,
        input logic [7:0] dmin,
        input logic [7:0] dmax,
        input logic [7:0] step
    );
        duty_step_t res;
        logic [8:0] up_sum;
        logic [7:0] up_val;
        logic [7:0] dn_val;

        up_sum = {1'b0, duty} + {1'b0, step};
        up_val = (up_sum > {1'b0, dmax}) ? dmax : up_sum[7:0];
        dn_val = ({1'b0, duty} < ({1'b0, dmin} + {1'b0, step})) ? dmin : (duty - step);

        res.duty = duty;
        res.dir  = dir;
        if (mode == ModeSaw) begin
            res.duty = (duty == dmax) ? dmin : up_val;
        end else if (dir == DirUp) begin
            if (duty == dmax) begin
                res.dir  = DirDown;
                res.duty = dn_val;
            end else begin
                res.duty = up_val;
            end
        end else begin
            if (duty == dmin) begin
                res.dir  = DirUp;
                res.duty = up_val;
            end else begin
                res.duty = dn_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_sweep_tick.sv
// Inter-update delay counter: loads CLK_DIV-1 on clear and counts down to zero.
// done_o is high while the count sits at zero.
module pwm_sweep_tick #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic done_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = CntLoad;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_sweep_master.sv
// Avalon-MM master that sweeps the duty register of a PWM slave (sawtooth or
// triangle), optionally reading each write back and counting mismatches.
module pwm_sweep_master
    import pwm_sweep_pkg::*;
#(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TARGET_ADDR = 0,
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned DUTY_MIN    = 0,
    parameter int unsigned DUTY_MAX    = 255,
    parameter int unsigned STEP        = 1,
    parameter int unsigned VERIFY      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              triangle_i,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_write_o,
    output logic [31:0]       avm_writedata_o,
    output logic              avm_read_o,
    input  logic [31:0]       avm_readdata_i,
    input  logic              avm_waitrequest_i,
    output logic              busy_o,
    output logic [7:0]        duty_o,
    output logic              mismatch_o,
    output logic [15:0]       err_count_o
);

    localparam logic [ADDR_W-1:0] TargetAddr = ADDR_W'(TARGET_ADDR);
    localparam logic [7:0]        DutyMin    = 8'(DUTY_MIN);
    localparam logic [7:0]        DutyMax    = 8'(DUTY_MAX);
    localparam logic [7:0]        Step       = 8'(STEP);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    dir_t              dir_q, dir_d;
    logic [7:0]        duty_q, duty_d;
    logic              stop_pend_q, stop_pend_d;
    logic              mismatch_q, mismatch_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              tick_clear, tick_done;
    duty_step_t        nd;

    pwm_sweep_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear_i(tick_clear),
        .done_o (tick_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mode_q      <= ModeSaw;
            dir_q       <= DirUp;
            duty_q      <= DutyMin;
            stop_pend_q <= 1'b0;
            mismatch_q  <= 1'b0;
            err_q       <= 16'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            wdata_q     <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            duty_q      <= duty_d;
            stop_pend_q <= stop_pend_d;
            mismatch_q  <= mismatch_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            read_q      <= read_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        duty_d      = duty_q;
        mismatch_d  = mismatch_q;
        err_d       = err_q;
        stop_pend_d = stop_pend_q | stop_i;
        nd          = next_duty(duty_q, dir_q, mode_q, DutyMin, DutyMax, Step);

        unique case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    state_d = StWrite;
                    duty_d  = DutyMin;
                    dir_d   = DirUp;
                    mode_d  = triangle_i ? ModeTri : ModeSaw;
                end
            end
            StWrite: begin
                if (!avm_waitrequest_i) begin
                    if (stop_pend_d) begin
                        state_d = StIdle;
                    end else if (VERIFY != 0) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWaitTick;
                    end
                end
            end
            StRead: begin
                if (!avm_waitrequest_i) begin
                    if (avm_readdata_i[7:0] != duty_q || avm_readdata_i[31:8] != 24'd0) begin
                        mismatch_d = 1'b1;
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                    end
                    state_d = stop_pend_d ? StIdle : StWaitTick;
                end
            end
            StWaitTick: begin
                if (stop_pend_d) begin
                    state_d = StIdle;
                end else if (tick_done) begin
                    state_d = StWrite;
                    duty_d  = nd.duty;
                    dir_d   = nd.dir;
                end
            end
            default: state_d = StIdle;
        endcase

        // A stop is consumed by (or irrelevant in) IDLE, so never carry it into a new sweep.
        if (state_d == StIdle) begin
            stop_pend_d = 1'b0;
        end
    end

    always_comb begin
        write_d    = (state_d == StWrite);
        read_d     = (state_d == StRead);
        busy_d     = (state_d != StIdle);
        addr_d     = (write_d || read_d) ? TargetAddr : addr_q;
        wdata_d    = write_d ? {24'd0, duty_d} : wdata_q;
        tick_clear = (state_d == StWaitTick) && (state_q != StWaitTick);
    end

    assign avm_address_o   = addr_q;
    assign avm_write_o     = write_q;
    assign avm_writedata_o = wdata_q;
    assign avm_read_o      = read_q;
    assign busy_o          = busy_q;
    assign duty_o          = duty_q;
    assign mismatch_o      = mismatch_q;
    assign err_count_o     = err_q;

endmodule
